mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the word-wide data RAM. It accepts one memory request at a time from the CPU execute stage and drives the RAM's d/ad/we lines, consuming q.
- Adds byte-granular access, which the RAM lacks. Byte loads extract and zero-extend the addressed byte. Byte stores run a read-modify-write sequence.
- RAM byte order is big-endian: the byte at address A is q[31:24] of a word read at A. RAM read latency is 1 cycle (q registered).

Parameters:
ADDR_WIDTH, 8, RAM byte-address width; request addresses masked to this many bits before driving ram_ad.

Ports:
clk  input  1  system clock, rising edge
nreset  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit idle, request accepted when req_valid & req_ready at clk edge
req_store  input  1  1 = store, 0 = load
req_byte  input  1  1 = byte access, 0 = word access
req_addr  input  `FULLW  byte address
req_wdata  input  `FULLW  store data; byte stores use req_wdata[7:0]
resp_valid  output  1  one-cycle pulse: operation complete
resp_rdata  output  `FULLW  load result, held until next load completes
resp_fault  output  1  alignment fault flag, valid with resp_valid
ram_d  output  `FULLW  RAM write data (registered)
ram_ad  output  `FULLW  RAM address (registered)
ram_we  output  1  RAM write enable (registered)
ram_q  input  `FULLW  RAM read data, valid the cycle after ram_ad is presented

Behaviour:
- Reset (nreset low at clk edge): state IDLE. ram_we/ram_d/ram_ad/resp_valid/resp_rdata/resp_fault = 0. req_ready = 0 while nreset is low, 1 in IDLE thereafter.
- Reset mid-operation aborts the sequence.
  - A ram_we already high in the cycle before the reset edge still completes in the RAM; this is not prevented.
  - No later RAM write occurs. No resp_valid is produced for the aborted op.
- req_ready = (state == IDLE). Requests are never queued; req_valid while busy is ignored.
- Acceptance edge: latch store, byte, addr[ADDR_WIDTH-1:0] zero-extended, and wdata.
- States: IDLE, ISSUE, RD_WAIT, WRITE, RESP.
- Word load: IDLE -> ISSUE (ram_ad = addr, ram_we = 0) -> RD_WAIT (ram_q valid) -> RESP (resp_rdata = ram_q). resp_valid is high in the 3rd cycle after the accept edge.
- Byte load: same sequence. resp_rdata = {24'b0, ram_q[31:24]}.
- Word store: IDLE -> ISSUE (ram_ad = addr, ram_d = wdata, ram_we = 1) -> RESP. resp_valid is high in the 2nd cycle after accept. resp_rdata is unchanged.
- Byte store (RMW): IDLE -> ISSUE (read, ram_we = 0) -> RD_WAIT -> WRITE (ram_ad = addr, ram_d = {wdata[7:0], ram_q[23:0]} captured at end of RD_WAIT, ram_we = 1) -> RESP. The 3 trailing bytes are rewritten with their read values.
- ram_we is high for exactly one cycle per store and never during loads.
- RESP always returns to IDLE on the next edge. Peak throughput is one op per 3 (word store), 4 (load) or 5 (byte store) cycles including the IDLE cycle.
- ram_ad and ram_d hold their last values outside ISSUE/WRITE. ram_we is 0 outside ISSUE/WRITE.
- No address wrap handling beyond the ADDR_WIDTH mask. A word access at the top 3 bytes follows RAM behaviour.

Optional Feature:
MAU_ALIGN_CHECK_EN
- Defined: a word request (req_byte = 0) with addr[1:0] != 0 makes no RAM access (ram_we stays 0). State goes IDLE -> RESP on the accept edge, with resp_valid = 1, resp_fault = 1 and resp_rdata unchanged. resp_fault = 0 for all other responses. Byte requests are never faulted.
- Undefined: resp_fault is tied 0. Misaligned word accesses are issued to the RAM unmodified.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> resp_rdata = 0xDEADBEEF. resp_valid 2 cycles after store accept and 3 cycles after load accept. ram_we high 1 cycle total.
- Byte store wdata 0x000000A5 @0x10 after the above, then word load @0x10 -> 0xA5ADBEEF. ram_we high only in WRITE. Byte load @0x13 -> 0x000000EF.
- Hold req_valid high with 2 distinct word loads queued by the bench -> second accepted only in IDLE after the first resp_valid. No request dropped or duplicated.
- Reset pulled low during RD_WAIT of a byte store @0x20 (preloaded 0x11223344) -> no ram_we, memory reads 0x11223344 afterwards, no resp_valid, req_ready = 1 the cycle after nreset rises.
- Address 0x1F3 with ADDR_WIDTH = 8 -> ram_ad = 0x000000F3.
- With MAU_ALIGN_CHECK_EN: word load @0x12 -> resp_valid and resp_fault in the cycle after accept, no RAM read issued, resp_rdata unchanged. Byte load @0x12 -> normal response, resp_fault = 0.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store sequencer between the CPU execute stage and a
//               word-wide, byte-addressed, big-endian data RAM with a
//               one-cycle registered read port. Adds byte loads
//               (zero-extended) and byte stores (read-modify-write).
//               One request is in flight at a time; req_valid while busy
//               is ignored.
// Ports       : clk, nreset                 clock, synchronous active-low reset
//               req_valid/req_ready         request handshake (ready = idle)
//               req_store, req_byte         operation kind
//               req_addr, req_wdata         byte address, store data
//               resp_valid                  one-cycle completion pulse
//               resp_rdata                  load result, held between loads
//               resp_fault                  misaligned-word fault flag
//               ram_d, ram_ad, ram_we       registered RAM controls
//               ram_q                       RAM read data (1-cycle latency)
// Options     : MAU_ALIGN_CHECK_EN - when defined, misaligned word requests
//               complete immediately with resp_fault = 1 and no RAM access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic        req_byte,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] ram_d,
   output logic [31:0] ram_ad,
   output logic        ram_we,
   input  logic [31:0] ram_q
);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_ISSUE   = 3'd1;
   localparam logic [2:0] c_RD_WAIT = 3'd2;
   localparam logic [2:0] c_WRITE   = 3'd3;
   localparam logic [2:0] c_RESP    = 3'd4;

   localparam logic [31:0] c_ADDR_MASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                       : ((32'd1 << ADDR_WIDTH) - 32'd1);

   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;

   // Request fields latched on the accept edge
   logic        r_store;
   logic        r_byte;
   logic [31:0] r_addr;
   logic [7:0]  r_wbyte;

   logic        w_accept;
   logic [31:0] w_addr_m;
   logic        w_fault_req;

   // Next values of the registered outputs
   logic        w_ram_we_nxt;
   logic [31:0] w_ram_d_nxt;
   logic [31:0] w_ram_ad_nxt;
   logic        w_resp_valid_nxt;
   logic [31:0] w_resp_rdata_nxt;
   logic        w_resp_fault_nxt;

   assign req_ready = nreset & (r_state == c_IDLE);
   assign w_accept  = req_valid & req_ready;
   assign w_addr_m  = req_addr & c_ADDR_MASK;

`ifdef MAU_ALIGN_CHECK_EN
   assign w_fault_req = ~req_byte & (req_addr[1:0] != 2'b00);
`else
   assign w_fault_req = 1'b0;
`endif

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_fault_req ? c_RESP : c_ISSUE;
            end
         end
         // Word stores finish in one RAM cycle; everything else reads first
         c_ISSUE:   w_state_nxt = (r_store && !r_byte) ? c_RESP : c_RD_WAIT;
         c_RD_WAIT: w_state_nxt = r_store ? c_WRITE : c_RESP;
         c_WRITE:   w_state_nxt = c_RESP;
         c_RESP:    w_state_nxt = c_IDLE;
         default:   w_state_nxt = c_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode: next values for the registered RAM/response outputs.
   // RAM address/data hold their previous values unless a RAM cycle is
   // launched; resp_rdata only changes when a load completes.
   // ------------------------------------------------------------------
   always_comb begin
      w_ram_we_nxt     = 1'b0;
      w_ram_d_nxt      = ram_d;
      w_ram_ad_nxt     = ram_ad;
      w_resp_valid_nxt = 1'b0;
      w_resp_rdata_nxt = resp_rdata;
      w_resp_fault_nxt = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (w_accept) begin
               if (w_fault_req) begin
                  w_resp_valid_nxt = 1'b1;
                  w_resp_fault_nxt = 1'b1;
               end else begin
                  w_ram_ad_nxt = w_addr_m;
                  if (req_store && !req_byte) begin
                     w_ram_we_nxt = 1'b1;
                     w_ram_d_nxt  = req_wdata;
                  end
               end
            end
         end
         c_ISSUE: begin
            if (r_store && !r_byte) begin
               w_resp_valid_nxt = 1'b1;
            end
         end
         c_RD_WAIT: begin
            if (r_store) begin
               // Byte store: merge new top byte with the three bytes just read
               w_ram_we_nxt = 1'b1;
               w_ram_ad_nxt = r_addr;
               w_ram_d_nxt  = {r_wbyte, ram_q[23:0]};
            end else begin
               w_resp_valid_nxt = 1'b1;
               w_resp_rdata_nxt = r_byte ? {24'h0, ram_q[31:24]} : ram_q;
            end
         end
         c_WRITE: begin
            w_resp_valid_nxt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output and request-latch registers. Reset clears ram_we on the reset
   // edge, so an aborted sequence can never write afterwards.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!nreset) begin
         ram_we     <= 1'b0;
         ram_d      <= 32'h0;
         ram_ad     <= 32'h0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_fault <= 1'b0;
         r_store    <= 1'b0;
         r_byte     <= 1'b0;
         r_addr     <= 32'h0;
         r_wbyte    <= 8'h0;
      end else begin
         ram_we     <= w_ram_we_nxt;
         ram_d      <= w_ram_d_nxt;
         ram_ad     <= w_ram_ad_nxt;
         resp_valid <= w_resp_valid_nxt;
         resp_rdata <= w_resp_rdata_nxt;
         resp_fault <= w_resp_fault_nxt;
         if (w_accept) begin
            r_store <= req_store;
            r_byte  <= req_byte;
            r_addr  <= w_addr_m;
            r_wbyte <= req_wdata[7:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a byte-addressed
//               big-endian RAM model. Stimulus pushes expected responses;
//               a monitor pops and compares on every resp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   logic        clk;
   logic        nreset;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic        req_byte;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] ram_d;
   logic [31:0] ram_ad;
   logic        ram_we;
   logic [31:0] ram_q;

   mem_access_unit #(.ADDR_WIDTH(8)) dut (
      .clk        (clk),
      .nreset     (nreset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_byte   (req_byte),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .ram_d      (ram_d),
      .ram_ad     (ram_ad),
      .ram_we     (ram_we),
      .ram_q      (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- RAM model: byte array, big-endian word view -------
   logic [7:0] mem [0:255];
   logic [7:0] a0, a1, a2, a3;
   assign a0 = ram_ad[7:0];
   assign a1 = a0 + 8'd1;
   assign a2 = a0 + 8'd2;
   assign a3 = a0 + 8'd3;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      ram_q = 32'h0;
   end

   always @(posedge clk) begin
      ram_q <= {mem[a0], mem[a1], mem[a2], mem[a3]};
      if (ram_we) begin
         mem[a0] <= ram_d[31:24];
         mem[a1] <= ram_d[23:16];
         mem[a2] <= ram_d[15:8];
         mem[a3] <= ram_d[7:0];
      end
   end

   // ---------------- bookkeeping -----------------------------------------
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int we_cnt  = 0;
   int last_we_cyc = 0;
   int last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ram_we) begin
         we_cnt      <= we_cnt + 1;
         last_we_cyc <= cyc;
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- monitor ---------------------------------------------
   always @(negedge clk) begin
      if (resp_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid rdata=%h expected no response (t=%0t)",
                     resp_rdata, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_fault", {31'h0, resp_fault}, {31'h0, e.fault});
            chk("resp_latency", cyc - e.acc + 1, e.lat);
         end
      end
   end

   // ---------------- stimulus helpers ------------------------------------
   // Holds req_valid at every edge until accepted; lat = cycle index after
   // the accept edge in which resp_valid must be high.
   task automatic issue(input logic st, input logic bt, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ex,
                        input logic fl, input int lat, input bit push);
      bit   ok;
      exp_t e;
      ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_store = st;
         req_byte  = bt;
         req_addr  = a;
         req_wdata = wd;
         if (req_ready) ok = 1'b1;
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 within 60 cycles");
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      last_acc  = cyc;
      req_valid = 1'b0;
      if (push) begin
         e.rdata = ex;
         e.fault = fl;
         e.lat   = lat;
         e.acc   = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) done = 1'b1;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL resp_timeout: got %0d responses outstanding expected 0", sb.size());
         sb.delete();
      end
   endtask

   // ---------------- directed sequence -----------------------------------
   int w0;
   int acc0;

   initial begin
      nreset    = 1'b0;
      req_valid = 1'b0;
      req_store = 1'b0;
      req_byte  = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_ram_ad", ram_ad, 32'h0);
      chk("rst_ram_d", ram_d, 32'h0);
      chk("rst_resp_fault", {31'h0, resp_fault}, 32'h0);
      nreset = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

      // Word store then word load
      w0 = we_cnt;
      issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
      drain();
      chk("wst_we_count", we_cnt - w0, 32'd1);
      chk("wst_we_cycle", last_we_cyc - last_acc, 32'd0);
      w0 = we_cnt;
      issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
      drain();
      chk("wld_no_we", we_cnt - w0, 32'd0);

      // Byte store (RMW), then loads
      w0 = we_cnt;
      issue(1'b1, 1'b1, 32'h10, 32'h000000A5, 32'hDEADBEEF, 1'b0, 4, 1'b1);
      drain();
      chk("bst_we_count", we_cnt - w0, 32'd1);
      chk("bst_we_cycle", last_we_cyc - last_acc, 32'd2);
      issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 3, 1'b1);
      issue(1'b0, 1'b1, 32'h13, 32'h0, 32'h000000EF, 1'b0, 3, 1'b1);
      drain();

      // Back-to-back loads with req_valid held high
      w0 = we_cnt;
      issue(1'b0, 1'b0, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 3, 1'b1);
      acc0 = last_acc;
      issue(1'b0, 1'b0, 32'h13, 32'h0, 32'hEF000000, 1'b0, 3, 1'b1);
      chk("b2b_accept_gap", last_acc - acc0, 32'd4);
      drain();
      chk("b2b_no_we", we_cnt - w0, 32'd0);

      // Address masking to ADDR_WIDTH
      issue(1'b1, 1'b0, 32'h1F3, 32'h01020304, 32'hEF000000, 1'b0, 2, 1'b1);
      @(negedge clk);
      chk("mask_ram_ad_store", ram_ad, 32'h000000F3);
      drain();
      issue(1'b0, 1'b0, 32'h1F3, 32'h0, 32'h01020304, 1'b0, 3, 1'b1);
      @(negedge clk);
      chk("mask_ram_ad_load", ram_ad, 32'h000000F3);
      drain();

      // Reset during RD_WAIT of a byte store
      issue(1'b1, 1'b0, 32'h20, 32'h11223344, 32'h01020304, 1'b0, 2, 1'b1);
      drain();
      w0 = we_cnt;
      issue(1'b1, 1'b1, 32'h20, 32'h00000099, 32'h0, 1'b0, 0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      nreset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_req_ready", {31'h0, req_ready}, 32'h0);
      chk("midrst_resp_rdata", resp_rdata, 32'h0);
      nreset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("postrst_req_ready", {31'h0, req_ready}, 32'h1);
      repeat (4) @(negedge clk);
      chk("abort_no_we", we_cnt - w0, 32'd0);
      issue(1'b0, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 3, 1'b1);
      drain();

      // Misaligned word access
`ifdef MAU_ALIGN_CHECK_EN
      issue(1'b0, 1'b0, 32'h12, 32'h0, 32'h11223344, 1'b1, 1, 1'b1);
      @(negedge clk);
      chk("fault_no_ram_access", ram_ad, 32'h00000020);
      drain();
`else
      issue(1'b0, 1'b0, 32'h12, 32'h0, 32'hBEEF0000, 1'b0, 3, 1'b1);
      drain();
`endif
      issue(1'b0, 1'b1, 32'h12, 32'h0, 32'h000000BE, 1'b0, 3, 1'b1);
      drain();

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
